if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port Clrn, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port stall, input, 1 bit: hazard unit request to freeze the IF/ID register.
REQ-005 SHALL have port redirect, input, 1 bit: taken branch or jump; discard the in-flight fetch.
REQ-006 SHALL have port redirect_pc, input, 32 bits: redirect target address.
REQ-007 SHALL have port imem_req, output, 1 bit: instruction memory request.
REQ-008 SHALL have port imem_addr, output, 32 bits: fetch address, word aligned.
REQ-009 SHALL have port imem_rdy, input, 1 bit: memory completes the request this cycle.
REQ-010 SHALL have port imem_rdata, input, 32 bits: instruction word, valid when imem_req and imem_rdy are both high.
REQ-011 SHALL have port pc4, output, 32 bits: fetched PC + 4; drives IF/ID D0.
REQ-012 SHALL have port inst, output, 32 bits: fetched instruction; drives IF/ID D1.
REQ-013 SHALL have port ifid_en, output, 1 bit: IF/ID load enable, 1-cycle strobe per delivered instruction.

Function
REQ-014 SHALL hold registers pc[31:0], state {FETCH, HOLD, FLUSH}, buf_inst[31:0] and tgt[31:0].
REQ-015 SHALL keep imem_addr equal to pc, driven from a register, and SHALL keep imem_req high in FETCH and FLUSH and low in HOLD.
REQ-016 SHALL NOT change imem_addr while imem_req=1 and imem_rdy=0.
REQ-017 In FETCH with rdy=1, redirect=0, stall=0: SHALL drive ifid_en=1, inst=imem_rdata and pc4=pc+4, set pc<=pc+4, and stay in FETCH.
REQ-018 In FETCH with rdy=1, redirect=0, stall=1: SHALL drive ifid_en=0, set buf_inst<=imem_rdata, and go to HOLD; pc is unchanged.
REQ-019 In HOLD with stall=0 and redirect=0: SHALL drive ifid_en=1, inst=buf_inst and pc4=pc+4, set pc<=pc+4, and go to FETCH.
REQ-020 In HOLD with stall=1: SHALL drive ifid_en=0 and hold all state.
REQ-021 Redirect has priority over stall in every state; ifid_en SHALL be 0 in any cycle where redirect=1.
REQ-022 Redirect in FETCH with rdy=1 or in HOLD: SHALL drop the data, set pc<={redirect_pc[31:2],2'b00}, and go to FETCH.
REQ-023 Redirect in FETCH with rdy=0: SHALL set tgt<={redirect_pc[31:2],2'b00} and go to FLUSH; pc is unchanged.
REQ-024 In FLUSH: ifid_en SHALL be 0; on rdy=1, SHALL drop the data, set pc<=tgt, and go to FETCH.
REQ-025 A further redirect in FLUSH SHALL overwrite tgt; with rdy=1 in the same cycle, pc SHALL load the new target.
REQ-026 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-027 When ifid_en=0, pc4 and inst are don't-care, but they SHALL NOT be X.
REQ-028 Latency: with rdy tied high and no stall, SHALL deliver one instruction per cycle, and the first ifid_en SHALL occur in the first cycle after reset release.

Reset
REQ-029 Clrn=0 at a rising edge SHALL set pc<=RESET_PC, state<=FETCH, buf_inst<=0 and tgt<=0.
REQ-030 While Clrn=0, imem_req and ifid_en SHALL be 0 combinationally.
REQ-031 Reset during an outstanding request SHALL abandon it; the returning data is ignored, and the memory tolerates the abandonment.
REQ-032 Reset SHALL override stall and redirect.

Verification
REQ-033 Reset, rdy=1, imem_rdata=addr: after release, three cycles SHALL give (pc4, inst) = (4,0), (8,4), (C,8), each with ifid_en=1.
REQ-034 rdy=0 for 2 cycles at pc=8, then 1: imem_addr SHALL stay 8 for 3 cycles, and ifid_en SHALL pulse once with inst=data(8).
REQ-035 stall=1 for 3 cycles while data(10) returns: state SHALL be HOLD, imem_req=0, ifid_en=0; on the cycle stall falls, SHALL give ifid_en=1, inst=data(10), pc4=14.
REQ-036 redirect to 40 while rdy=0 at pc=20: addr SHALL stay 20 until rdy, the data SHALL be dropped, and the next imem_addr SHALL be 40 with no ifid_en for 20.
REQ-037 redirect_pc=33 in HOLD with stall=1: SHALL discard buf_inst and give next imem_addr=30; plus wrap: pc=FFFF_FFFC delivered with pc4=0, next fetch at 0.
REQ-038 Clrn=0 mid-FLUSH with tgt=80: the next fetch after release SHALL be at RESET_PC, not 80.

Source files
------------

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory port and
// the IF/ID register feed. The fetch unit takes the master modport; the
// environment (hazard unit, memory, IF/ID register) takes the slave modport.
interface if_fetch_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_rdata;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        ifid_en;

    modport master (
        input  stall,
        input  redirect,
        input  redirect_pc,
        output imem_req,
        output imem_addr,
        input  imem_rdy,
        input  imem_rdata,
        output pc4,
        output inst,
        output ifid_en
    );

    modport slave (
        output stall,
        output redirect,
        output redirect_pc,
        input  imem_req,
        input  imem_addr,
        output imem_rdy,
        output imem_rdata,
        input  pc4,
        input  inst,
        input  ifid_en
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: keeps the PC, issues word-aligned fetches to the
// instruction memory and hands one instruction per strobe to the IF/ID
// register. A returned word is parked in a buffer while the pipeline is
// stalled, and a redirect that arrives during an unfinished request is
// remembered until that request completes so its data can be discarded.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic        Clk,
    input logic        Clrn,
    if_fetch_if.master bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_buf_inst;
    logic [31:0] w_buf_inst_nxt;
    logic [31:0] r_tgt;
    logic [31:0] w_tgt_nxt;

    logic [31:0] w_redirect_tgt;
    logic [31:0] w_pc_plus4;
    logic        w_deliver;
    logic        w_use_buf;
    logic        w_ifid_en;

    // Redirect targets are forced onto a word boundary.
    assign w_redirect_tgt = bus.redirect_pc & ~32'd3;
    // Wraps naturally modulo 2^32.
    assign w_pc_plus4     = r_pc + 32'd4;

    // Next-state and delivery decode; redirect always beats stall.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_buf_inst_nxt = r_buf_inst;
        w_tgt_nxt      = r_tgt;
        w_deliver      = 1'b0;
        w_use_buf      = 1'b0;

        case (r_state)
            FETCH: begin
                if (bus.imem_rdy) begin
                    if (bus.redirect) begin
                        w_pc_nxt = w_redirect_tgt;
                    end else if (bus.stall) begin
                        w_buf_inst_nxt = bus.imem_rdata;
                        w_state_nxt    = HOLD;
                    end else begin
                        w_deliver = 1'b1;
                        w_pc_nxt  = w_pc_plus4;
                    end
                end else if (bus.redirect) begin
                    // Address must stay put until the memory answers.
                    w_tgt_nxt   = w_redirect_tgt;
                    w_state_nxt = FLUSH;
                end
            end

            HOLD: begin
                w_use_buf = 1'b1;
                if (bus.redirect) begin
                    w_pc_nxt    = w_redirect_tgt;
                    w_state_nxt = FETCH;
                end else if (!bus.stall) begin
                    w_deliver   = 1'b1;
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = FETCH;
                end
            end

            FLUSH: begin
                if (bus.redirect) begin
                    w_tgt_nxt = w_redirect_tgt;
                end
                if (bus.imem_rdy) begin
                    // A redirect landing in the completing cycle wins over tgt.
                    w_pc_nxt    = bus.redirect ? w_redirect_tgt : r_tgt;
                    w_state_nxt = FETCH;
                end
            end

            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_buf_inst <= '0;
            r_tgt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_buf_inst <= w_buf_inst_nxt;
            r_tgt      <= w_tgt_nxt;
        end
    end

    assign w_ifid_en     = Clrn & w_deliver;

    assign bus.imem_req  = Clrn & (r_state != HOLD);
    assign bus.imem_addr = r_pc;
    assign bus.ifid_en   = w_ifid_en;
    assign bus.pc4       = w_pc_plus4;
    // Zeroed when not strobing so an undriven memory bus never leaks X.
    assign bus.inst      = !w_ifid_en ? '0 :
                           (w_use_buf ? r_buf_inst : bus.imem_rdata);

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch. The memory returns its own address as data
// when a request completes and a poison word otherwise. Inputs change just
// after the falling edge; outputs are checked 1 ns later.
module tb_if_fetch;

    logic Clk;
    logic Clrn;
    int   n_pass;
    int   n_total;

    if_fetch_if bus ();

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .Clk  (Clk),
        .Clrn (Clrn),
        .bus  (bus)
    );

    assign bus.imem_rdata = (bus.imem_req && bus.imem_rdy) ? bus.imem_addr : 32'hDEAD_BEEF;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic do_reset();
        @(negedge Clk);
        Clrn = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0;
        bus.redirect_pc = '0; bus.imem_rdy = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Clrn = 1'b1;
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Clrn = 1'b0; bus.stall = 1'b1; bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0100; bus.imem_rdy = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        #1;
        n_total++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", bus.imem_req); else n_pass++;
        n_total++; if (bus.ifid_en !== 1'b0) $display("FAIL reset_en: got %0b want 0", bus.ifid_en); else n_pass++;
        n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 00000000", bus.imem_addr); else n_pass++;
        n_total++; if (bus.inst !== 32'h0) $display("FAIL reset_inst: got %h want 00000000", bus.inst); else n_pass++;
        bus.stall = 1'b0; bus.redirect = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        #1;
        n_total++; if (bus.ifid_en !== 1'b1) $display("FAIL stream0_en: got %0b want 1", bus.ifid_en); else n_pass++;
        n_total++; if (bus.pc4 !== 32'h4) $display("FAIL stream0_pc4: got %h want 00000004", bus.pc4); else n_pass++;
        n_total++; if (bus.inst !== 32'h0) $display("FAIL stream0_inst: got %h want 00000000", bus.inst); else n_pass++;
        @(negedge Clk); #1;
        n_total++; if (bus.ifid_en !== 1'b1) $display("FAIL stream1_en: got %0b want 1", bus.ifid_en); else n_pass++;
        n_total++; if (bus.pc4 !== 32'h8) $display("FAIL stream1_pc4: got %h want 00000008", bus.pc4); else n_pass++;
        n_total++; if (bus.inst !== 32'h4) $display("FAIL stream1_inst: got %h want 00000004", bus.inst); else n_pass++;
        @(negedge Clk); #1;
        n_total++; if (bus.ifid_en !== 1'b1) $display("FAIL stream2_en: got %0b want 1", bus.ifid_en); else n_pass++;
        n_total++; if (bus.pc4 !== 32'hC) $display("FAIL stream2_pc4: got %h want 0000000c", bus.pc4); else n_pass++;
        n_total++; if (bus.inst !== 32'h8) $display("FAIL stream2_inst: got %h want 00000008", bus.inst); else n_pass++;
    endtask

    task automatic test_wait();
        do_reset();
        advance(2);
        bus.imem_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_total++; if (bus.imem_addr !== 32'h8) $display("FAIL wait%0d_addr: got %h want 00000008", i, bus.imem_addr); else n_pass++;
            n_total++; if (bus.ifid_en !== 1'b0) $display("FAIL wait%0d_en: got %0b want 0", i, bus.ifid_en); else n_pass++;
            n_total++; if (bus.imem_req !== 1'b1) $display("FAIL wait%0d_req: got %0b want 1", i, bus.imem_req); else n_pass++;
            @(negedge Clk);
        end
        bus.imem_rdy = 1'b1;
        #1;
        n_total++; if (bus.imem_addr !== 32'h8) $display("FAIL wait_done_addr: got %h want 00000008", bus.imem_addr); else n_pass++;
        n_total++; if (bus.ifid_en !== 1'b1) $display("FAIL wait_done_en: got %0b want 1", bus.ifid_en); else n_pass++;
        n_total++; if (bus.inst !== 32'h8) $display("FAIL wait_done_inst: got %h want 00000008", bus.inst); else n_pass++;
        n_total++; if (bus.pc4 !== 32'hC) $display("FAIL wait_done_pc4: got %h want 0000000c", bus.pc4); else n_pass++;
        @(negedge Clk); #1;
        n_total++; if (bus.imem_addr !== 32'hC) $display("FAIL wait_next_addr: got %h want 0000000c", bus.imem_addr); else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        advance(4);
        bus.stall = 1'b1;
        #1;
        n_total++; if (bus.ifid_en !== 1'b0) $display("FAIL stall_cap_en: got %0b want 0", bus.ifid_en); else n_pass++;
        n_total++; if (bus.imem_req !== 1'b1) $display("FAIL stall_cap_req: got %0b want 1", bus.imem_req); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk); #1;
            n_total++; if (bus.imem_req !== 1'b0) $display("FAIL stall_hold%0d_req: got %0b want 0", i, bus.imem_req); else n_pass++;
            n_total++; if (bus.ifid_en !== 1'b0) $display("FAIL stall_hold%0d_en: got %0b want 0", i, bus.ifid_en); else n_pass++;
            n_total++; if (bus.imem_addr !== 32'h10) $display("FAIL stall_hold%0d_addr: got %h want 00000010", i, bus.imem_addr); else n_pass++;
        end
        @(negedge Clk);
        bus.stall = 1'b0;
        #1;
        n_total++; if (bus.ifid_en !== 1'b1) $display("FAIL stall_rel_en: got %0b want 1", bus.ifid_en); else n_pass++;
        n_total++; if (bus.inst !== 32'h10) $display("FAIL stall_rel_inst: got %h want 00000010", bus.inst); else n_pass++;
        n_total++; if (bus.pc4 !== 32'h14) $display("FAIL stall_rel_pc4: got %h want 00000014", bus.pc4); else n_pass++;
        @(negedge Clk); #1;
        n_total++; if (bus.imem_addr !== 32'h14) $display("FAIL stall_next_addr: got %h want 00000014", bus.imem_addr); else n_pass++;
        n_total++; if (bus.inst !== 32'h14) $display("FAIL stall_next_inst: got %h want 00000014", bus.inst); else n_pass++;
    endtask

    task automatic test_redirect_flush();
        do_reset();
        advance(8);
        bus.imem_rdy = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
        #1;
        n_total++; if (bus.ifid_en !== 1'b0) $display("FAIL flush_req_en: got %0b want 0", bus.ifid_en); else n_pass++;
        n_total++; if (bus.imem_addr !== 32'h20) $display("FAIL flush_req_addr: got %h want 00000020", bus.imem_addr); else n_pass++;
        @(negedge Clk);
        bus.redirect = 1'b0;
        #1;
        n_total++; if (bus.imem_addr !== 32'h20) $display("FAIL flush_wait_addr: got %h want 00000020", bus.imem_addr); else n_pass++;
        n_total++; if (bus.imem_req !== 1'b1) $display("FAIL flush_wait_req: got %0b want 1", bus.imem_req); else n_pass++;
        @(negedge Clk);
        bus.imem_rdy = 1'b1;
        #1;
        n_total++; if (bus.ifid_en !== 1'b0) $display("FAIL flush_drop_en: got %0b want 0", bus.ifid_en); else n_pass++;
        n_total++; if (bus.imem_addr !== 32'h20) $display("FAIL flush_drop_addr: got %h want 00000020", bus.imem_addr); else n_pass++;
        @(negedge Clk); #1;
        n_total++; if (bus.imem_addr !== 32'h40) $display("FAIL flush_tgt_addr: got %h want 00000040", bus.imem_addr); else n_pass++;
        n_total++; if (bus.inst !== 32'h40) $display("FAIL flush_tgt_inst: got %h want 00000040", bus.inst); else n_pass++;
        n_total++; if (bus.pc4 !== 32'h44) $display("FAIL flush_tgt_pc4: got %h want 00000044", bus.pc4); else n_pass++;
    endtask

    task automatic test_flush_retarget();
        do_reset();
        bus.imem_rdy = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h60;
        @(negedge Clk);
        bus.redirect_pc = 32'h70;
        @(negedge Clk);
        bus.redirect = 1'b0; bus.imem_rdy = 1'b1;
        #1;
        n_total++; if (bus.ifid_en !== 1'b0) $display("FAIL retgt_drop_en: got %0b want 0", bus.ifid_en); else n_pass++;
        @(negedge Clk); #1;
        n_total++; if (bus.imem_addr !== 32'h70) $display("FAIL retgt_addr: got %h want 00000070", bus.imem_addr); else n_pass++;
        bus.imem_rdy = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h60;
        @(negedge Clk);
        bus.imem_rdy = 1'b1; bus.redirect_pc = 32'h74;
        #1;
        n_total++; if (bus.ifid_en !== 1'b0) $display("FAIL retgt_same_en: got %0b want 0", bus.ifid_en); else n_pass++;
        @(negedge Clk);
        bus.redirect = 1'b0;
        #1;
        n_total++; if (bus.imem_addr !== 32'h74) $display("FAIL retgt_same_addr: got %h want 00000074", bus.imem_addr); else n_pass++;
    endtask

    task automatic test_redirect_hold_wrap();
        do_reset();
        advance(2);
        bus.stall = 1'b1;
        @(negedge Clk);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h33;
        #1;
        n_total++; if (bus.ifid_en !== 1'b0) $display("FAIL hold_redir_en: got %0b want 0", bus.ifid_en); else n_pass++;
        @(negedge Clk);
        bus.redirect = 1'b0; bus.stall = 1'b0;
        #1;
        n_total++; if (bus.imem_addr !== 32'h30) $display("FAIL hold_redir_addr: got %h want 00000030", bus.imem_addr); else n_pass++;
        n_total++; if (bus.inst !== 32'h30) $display("FAIL hold_redir_inst: got %h want 00000030", bus.inst); else n_pass++;
        bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        @(negedge Clk);
        bus.redirect = 1'b0;
        #1;
        n_total++; if (bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h want fffffffc", bus.imem_addr); else n_pass++;
        n_total++; if (bus.ifid_en !== 1'b1) $display("FAIL wrap_en: got %0b want 1", bus.ifid_en); else n_pass++;
        n_total++; if (bus.pc4 !== 32'h0) $display("FAIL wrap_pc4: got %h want 00000000", bus.pc4); else n_pass++;
        n_total++; if (bus.inst !== 32'hFFFF_FFFC) $display("FAIL wrap_inst: got %h want fffffffc", bus.inst); else n_pass++;
        @(negedge Clk); #1;
        n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL wrap_next_addr: got %h want 00000000", bus.imem_addr); else n_pass++;
    endtask

    task automatic test_reset_in_flush();
        do_reset();
        advance(2);
        bus.imem_rdy = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h80;
        @(negedge Clk);
        bus.redirect = 1'b0; Clrn = 1'b0;
        #1;
        n_total++; if (bus.imem_req !== 1'b0) $display("FAIL rstfl_req: got %0b want 0", bus.imem_req); else n_pass++;
        n_total++; if (bus.ifid_en !== 1'b0) $display("FAIL rstfl_en: got %0b want 0", bus.ifid_en); else n_pass++;
        @(negedge Clk);
        Clrn = 1'b1; bus.imem_rdy = 1'b1;
        #1;
        n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL rstfl_addr: got %h want 00000000", bus.imem_addr); else n_pass++;
        n_total++; if (bus.ifid_en !== 1'b1) $display("FAIL rstfl_first_en: got %0b want 1", bus.ifid_en); else n_pass++;
        @(negedge Clk); #1;
        n_total++; if (bus.imem_addr !== 32'h4) $display("FAIL rstfl_next_addr: got %h want 00000004", bus.imem_addr); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        Clrn = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_rdy = 1'b0;
        test_reset();
        test_stream();
        test_wait();
        test_stall();
        test_redirect_flush();
        test_flush_retarget();
        test_redirect_hold_wrap();
        test_reset_in_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
